// File: rtl/mlp2_seq_engine.sv
// Time-multiplexed two-layer perceptron: one signed MAC walks the hidden layer (ReLU),
// then the output layer; weights and biases live in a runtime-writable register file.
module mlp2_seq_engine #(
  parameter int N_IN   = 4,
  parameter int N_HID  = 4,
  parameter int N_OUT  = 2,
  parameter int DW     = 8,
  parameter int OW     = 16,
  parameter int ACC_W  = 32,
  parameter int CFG_AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*DW-1:0]    in_data,
  input  logic                  relu_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*OW-1:0]   out_data,
  input  logic                  cfg_we,
  input  logic [CFG_AW-1:0]     cfg_addr,
  input  logic [DW-1:0]         cfg_wdata,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int NCFG    = N_IN*N_HID + N_HID + N_HID*N_OUT + N_OUT;
  localparam int B1_BASE = N_IN*N_HID;
  localparam int W2_BASE = B1_BASE + N_HID;
  localparam int B2_BASE = W2_BASE + N_HID*N_OUT;
  localparam int CNT_W   = 16;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in OUT, and out_data is held while stalled.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_L1 = 2'd1, S_L2 = 2'd2, S_OUT = 2'd3} state_e;

  state_e                   state_q, state_d;
  logic [NCFG*DW-1:0]       cfg_q, cfg_d;
  logic [N_IN*DW-1:0]       x_q, x_d;
  logic [N_HID*OW-1:0]      h_q, h_d;
  logic [N_OUT*OW-1:0]      y_q, y_d;
  logic                     relu_q, relu_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         outer_q, outer_d;
  logic [CNT_W-1:0]         inner_q, inner_d;

  logic signed [ACC_W-1:0]  mac_a, mac_b, mac_base, mac_sum, mac_pos;
  int                       oi, ii;

  function automatic logic signed [ACC_W-1:0] sext_dw(input logic [DW-1:0] v);
    return {{(ACC_W-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_ow(input logic [OW-1:0] v);
    return {{(ACC_W-OW){v[OW-1]}}, v};
  endfunction

  function automatic logic [OW-1:0] sat_ow(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
    lo = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};
    if (v > hi)      return hi[OW-1:0];
    else if (v < lo) return lo[OW-1:0];
    else             return v[OW-1:0];
  endfunction

  assign oi = int'(outer_q);
  assign ii = int'(inner_q);

  // Operand mux for the single shared MAC; the bias seeds the first term of each neuron.
  always_comb begin
    mac_a    = '0;
    mac_b    = '0;
    mac_base = acc_q;
    if (state_q == S_L1) begin
      mac_a = sext_dw(x_q[ii*DW +: DW]);
      mac_b = sext_dw(cfg_q[(ii*N_HID + oi)*DW +: DW]);
      if (ii == 0) mac_base = sext_dw(cfg_q[(B1_BASE + oi)*DW +: DW]);
    end else if (state_q == S_L2) begin
      mac_a = sext_ow(h_q[ii*OW +: OW]);
      mac_b = sext_dw(cfg_q[(W2_BASE + ii*N_OUT + oi)*DW +: DW]);
      if (ii == 0) mac_base = sext_dw(cfg_q[(B2_BASE + oi)*DW +: DW]);
    end
  end

  assign mac_sum = mac_base + mac_a * mac_b;
  assign mac_pos = mac_sum[ACC_W-1] ? '0 : mac_sum;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    x_d     = x_q;
    h_d     = h_q;
    y_d     = y_q;
    relu_d  = relu_q;
    acc_d   = acc_q;
    outer_d = outer_q;
    inner_d = inner_q;

    if (cfg_we && state_q == S_IDLE && int'(cfg_addr) < NCFG)
      cfg_d[int'(cfg_addr)*DW +: DW] = cfg_wdata;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          relu_d  = relu_out;
          outer_d = '0;
          inner_d = '0;
          state_d = S_L1;
        end
      end
      S_L1: begin
        acc_d = mac_sum;
        if (ii == N_IN-1) begin
          h_d[oi*OW +: OW] = sat_ow(mac_pos);
          inner_d = '0;
          if (oi == N_HID-1) begin
            outer_d = '0;
            state_d = S_L2;
          end else begin
            outer_d = outer_q + CNT_W'(1);
          end
        end else begin
          inner_d = inner_q + CNT_W'(1);
        end
      end
      S_L2: begin
        acc_d = mac_sum;
        if (ii == N_HID-1) begin
          y_d[oi*OW +: OW] = sat_ow(relu_q ? mac_pos : mac_sum);
          inner_d = '0;
          if (oi == N_OUT-1) begin
            outer_d = '0;
            state_d = S_OUT;
          end else begin
            outer_d = outer_q + CNT_W'(1);
          end
        end else begin
          inner_d = inner_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      x_q     <= '0;
      h_q     <= '0;
      y_q     <= '0;
      relu_q  <= 1'b0;
      acc_q   <= '0;
      outer_q <= '0;
      inner_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      x_q     <= x_d;
      h_q     <= h_d;
      y_q     <= y_d;
      relu_q  <= relu_d;
      acc_q   <= acc_d;
      outer_q <= outer_d;
      inner_q <= inner_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = y_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mlp2_seq_engine.sv
// Self-checking bench for mlp2_seq_engine: directed test-plan vectors plus random
// weights/inputs compared against a plain-arithmetic reference model.
module tb_mlp2_seq_engine;

  localparam int N_IN   = 4;
  localparam int N_HID  = 4;
  localparam int N_OUT  = 2;
  localparam int DW     = 8;
  localparam int OW     = 16;
  localparam int ACC_W  = 32;
  localparam int CFG_AW = 5;
  localparam int LAT    = N_HID*N_IN + N_OUT*N_HID;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*DW-1:0]   in_data;
  logic                 relu_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_OUT*OW-1:0]  out_data;
  logic                 cfg_we;
  logic [CFG_AW-1:0]    cfg_addr;
  logic [DW-1:0]        cfg_wdata;
  logic                 busy;
  logic [1:0]           dbg_state;

  int checks = 0;
  int errors = 0;

  int m_w1[N_IN][N_HID];
  int m_b1[N_HID];
  int m_w2[N_HID][N_OUT];
  int m_b2[N_OUT];
  logic [N_OUT*OW-1:0] exp_q[$];

  mlp2_seq_engine #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .OW(OW),
    .ACC_W(ACC_W), .CFG_AW(CFG_AW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .relu_out(relu_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (OW-1)) - 1;
    lo = -(longint'(1) <<< (OW-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [N_OUT*OW-1:0] model(input int x[N_IN], input bit relu);
    longint h[N_HID];
    longint s;
    logic [N_OUT*OW-1:0] r;
    r = '0;
    for (int i = 0; i < N_HID; i++) begin
      s = m_b1[i];
      for (int j = 0; j < N_IN; j++) s += longint'(x[j]) * m_w1[j][i];
      h[i] = clamp((s < 0) ? 0 : s);
    end
    for (int k = 0; k < N_OUT; k++) begin
      s = m_b2[k];
      for (int i = 0; i < N_HID; i++) s += h[i] * m_w2[i][k];
      if (relu && s < 0) s = 0;
      s = clamp(s);
      r[k*OW +: OW] = s[OW-1:0];
    end
    return r;
  endfunction

  function automatic logic [N_IN*DW-1:0] pack(input int x[N_IN]);
    logic [N_IN*DW-1:0] p;
    logic [31:0] t;
    p = '0;
    for (int j = 0; j < N_IN; j++) begin
      t = x[j];
      p[j*DW +: DW] = t[DW-1:0];
    end
    return p;
  endfunction

  function automatic int rnd_s8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = CFG_AW'(addr);
    cfg_wdata = DW'(data);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_cfg();
    for (int j = 0; j < N_IN; j++)
      for (int i = 0; i < N_HID; i++) cfg_write(j*N_HID + i, m_w1[j][i]);
    for (int i = 0; i < N_HID; i++) cfg_write(N_IN*N_HID + i, m_b1[i]);
    for (int i = 0; i < N_HID; i++)
      for (int k = 0; k < N_OUT; k++) cfg_write(N_IN*N_HID + N_HID + i*N_OUT + k, m_w2[i][k]);
    for (int k = 0; k < N_OUT; k++) cfg_write(N_IN*N_HID + N_HID + N_HID*N_OUT + k, m_b2[k]);
  endtask

  task automatic set_plan_weights();
    m_w1 = '{'{1, 2, 1, 0}, '{0, 1, 2, 1}, '{1, 0, 1, 2}, '{2, 1, 0, 1}};
    m_b1 = '{1, 1, 1, 1};
    m_w2 = '{'{1, 0}, '{0, 1}, '{1, 1}, '{0, 1}};
    m_b2 = '{0, 0};
  endtask

  task automatic set_random_weights();
    for (int j = 0; j < N_IN; j++)
      for (int i = 0; i < N_HID; i++) m_w1[j][i] = rnd_s8();
    for (int i = 0; i < N_HID; i++) m_b1[i] = rnd_s8();
    for (int i = 0; i < N_HID; i++)
      for (int k = 0; k < N_OUT; k++) m_w2[i][k] = rnd_s8();
    for (int k = 0; k < N_OUT; k++) m_b2[k] = rnd_s8();
  endtask

  // Sends one vector, checks acceptance, latency, result and handoff.
  task automatic run_vec(input int x[N_IN], input bit relu, output logic [N_OUT*OW-1:0] got);
    logic [N_OUT*OW-1:0] e;
    int lat;
    exp_q.push_back(model(x, relu));
    @(negedge clk);
    in_data   = pack(x);
    relu_out  = relu;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    relu_out = ~relu;
    in_data  = {$urandom, $urandom};
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept: busy=%b required 1", busy);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = out_data;
    e = exp_q.pop_front();
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL latency: got %0d cycles required %0d", lat, LAT);
    end
    checks++;
    if (out_data !== e) begin
      errors++;
      $display("FAIL result: got %h required %h", out_data, e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handoff: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; relu_out = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h required 1/0/0/0",
               in_ready, out_valid, busy, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_plan_vectors();
    int x[N_IN];
    logic [N_OUT*OW-1:0] got, lit;
    set_plan_weights();
    load_cfg();
    x = '{1, 2, 3, 4};
    run_vec(x, 1'b0, got);
    lit = {16'd31, 16'd22};
    checks++;
    if (got !== lit) begin
      errors++;
      $display("FAIL plan_y: got %h required %h", got, lit);
    end
    x = '{-10, -10, -10, -10};
    run_vec(x, 1'b0, got);
    lit = '0;
    checks++;
    if (got !== lit) begin
      errors++;
      $display("FAIL relu_hidden_zero: got %h required %h", got, lit);
    end
  endtask

  task automatic test_saturation();
    int x[N_IN];
    logic [N_OUT*OW-1:0] got, lit;
    for (int j = 0; j < N_IN; j++)
      for (int i = 0; i < N_HID; i++) m_w1[j][i] = 127;
    for (int i = 0; i < N_HID; i++) m_b1[i] = 127;
    for (int i = 0; i < N_HID; i++)
      for (int k = 0; k < N_OUT; k++) m_w2[i][k] = -128;
    for (int k = 0; k < N_OUT; k++) m_b2[k] = 0;
    load_cfg();
    x = '{127, 127, 127, 127};
    run_vec(x, 1'b0, got);
    lit = {16'h8000, 16'h8000};
    checks++;
    if (got !== lit) begin
      errors++;
      $display("FAIL sat_neg: got %h required %h", got, lit);
    end
    run_vec(x, 1'b1, got);
    lit = '0;
    checks++;
    if (got !== lit) begin
      errors++;
      $display("FAIL sat_relu: got %h required %h", got, lit);
    end
  endtask

  task automatic test_backpressure();
    int x1[N_IN];
    int x2[N_IN];
    logic [N_OUT*OW-1:0] e1, e2;
    int lat;
    bit r2;
    set_plan_weights();
    load_cfg();
    x1 = '{1, 2, 3, 4};
    for (int j = 0; j < N_IN; j++) x2[j] = rnd_s8();
    r2 = 1'($urandom_range(0, 1));
    e1 = model(x1, 1'b0);
    e2 = model(x2, r2);
    @(negedge clk);
    in_data = pack(x1); relu_out = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL bp_latency: got %0d required %0d", lat, LAT);
    end
    @(negedge clk);
    in_data = pack(x2); relu_out = r2; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== e1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c=%0d: out_valid=%b out_data=%h in_ready=%b required 1/%h/0",
                 c, out_valid, out_data, in_ready, e1);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    relu_out = ~r2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: busy=%b required 1", busy);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== LAT || out_data !== e2) begin
      errors++;
      $display("FAIL bp_second: lat=%0d data=%h required %0d/%h", lat, out_data, LAT, e2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cfg_ignore();
    int x[N_IN];
    logic [N_OUT*OW-1:0] got, got_busy, lit;
    set_plan_weights();
    load_cfg();
    x = '{1, 2, 3, 4};
    lit = {16'd31, 16'd22};
    fork
      run_vec(x, 1'b0, got_busy);
      begin
        repeat (6) @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 8'd5;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
      end
    join
    checks++;
    if (got_busy !== lit) begin
      errors++;
      $display("FAIL cfg_busy_run: got %h required %h", got_busy, lit);
    end
    cfg_write(31, 5);
    run_vec(x, 1'b0, got);
    checks++;
    if (got !== lit) begin
      errors++;
      $display("FAIL cfg_ignored: got %h required %h", got, lit);
    end
  endtask

  task automatic test_random();
    int x[N_IN];
    logic [N_OUT*OW-1:0] got;
    for (int set = 0; set < 2; set++) begin
      set_random_weights();
      load_cfg();
      for (int v = 0; v < 8; v++) begin
        for (int j = 0; j < N_IN; j++) x[j] = rnd_s8();
        run_vec(x, 1'($urandom_range(0, 1)), got);
      end
    end
  endtask

  task automatic test_reset_mid();
    int x[N_IN];
    logic [N_OUT*OW-1:0] got, lit;
    set_plan_weights();
    load_cfg();
    x = '{4, 3, 2, 1};
    @(negedge clk);
    in_data = pack(x); relu_out = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b out_data=%h in_ready=%b busy=%b required 0/0/1/0",
               out_valid, out_data, in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < N_IN; j++)
      for (int i = 0; i < N_HID; i++) m_w1[j][i] = 0;
    for (int i = 0; i < N_HID; i++) m_b1[i] = 0;
    for (int i = 0; i < N_HID; i++)
      for (int k = 0; k < N_OUT; k++) m_w2[i][k] = 0;
    for (int k = 0; k < N_OUT; k++) m_b2[k] = 0;
    for (int j = 0; j < N_IN; j++) x[j] = rnd_s8();
    run_vec(x, 1'b0, got);
    lit = '0;
    checks++;
    if (got !== lit) begin
      errors++;
      $display("FAIL after_reset_zero: got %h required %h", got, lit);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_plan_vectors();
    test_saturation();
    test_backpressure();
    test_cfg_ignore();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
